// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin write arbiter sharing one FIFO write port
// among N valid/ready requesters. A local credit counter mirrors FIFO
// occupancy from observed pops so the FIFO can never be overrun; the
// FIFO full flag is honoured as a second guard.
// Optional build macro FIFO_ARB_STATS_EN adds per-requester beat counters
// readable through stat_sel / stat_cnt.
module fifo_wr_arbiter #(
   parameter int N         = 4,
   parameter int DW        = 8,
   parameter int DEPTH     = 8,
   parameter int MAX_BURST = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N-1:0]    req_valid,
   input  logic [N*DW-1:0] req_data,
   output logic [N-1:0]    req_ready,
   output logic            fifo_wr,
   output logic [DW-1:0]   fifo_din,
   input  logic            fifo_full,
   input  logic            fifo_pop,
   output logic [N-1:0]    grant,
   output logic [3:0]      credit,
   output logic            ovf_err
`ifdef FIFO_ARB_STATS_EN
   ,
   input  logic [2:0]      stat_sel,
   output logic [15:0]     stat_cnt
`endif
);

   localparam int         PW        = $clog2(N);
   localparam logic [3:0] CRD_MAX   = 4'(DEPTH);
   localparam logic [3:0] LAST_BEAT = 4'(MAX_BURST - 1);

   typedef enum logic {IDLE, BURST} state_t;

   state_t            state, state_nxt;
   logic [PW-1:0]     owner, rr_ptr, winner;
   logic [3:0]        beat_cnt;
   logic              found, can_wr, owner_vld, beat, last_beat, exit_burst;
   logic [2*N-1:0]    vld_dbl;
   logic [N-1:0]      vld_rot;
   logic [PW:0]       offs, widx;
   logic [DW-1:0]     data_arr [N];

   // Unpack the flat requester data bus into one word per requester
   always_comb begin
      for (int i = 0; i < N; i++) data_arr[i] = req_data[i*DW +: DW];
   end

   // Round-robin search: rotate valids so rr_ptr sits at bit 0, take the lowest set bit
   always_comb begin
      vld_dbl = {req_valid, req_valid} >> rr_ptr;
      vld_rot = vld_dbl[N-1:0];
      found   = 1'b0;
      offs    = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (vld_rot[k]) begin
            found = 1'b1;
            offs  = (PW+1)'(k);
         end
      end
      widx = {1'b0, rr_ptr} + offs;
      if (widx >= (PW+1)'(N)) widx = widx - (PW+1)'(N);
      winner = widx[PW-1:0];
   end

   // Handshake qualifiers for the current owner
   always_comb begin
      can_wr     = (credit != 4'd0) && !fifo_full;
      owner_vld  = req_valid[owner];
      beat       = (state == BURST) && owner_vld && can_wr;
      last_beat  = beat && (beat_cnt == LAST_BEAT);
      exit_burst = (state == BURST) && (last_beat || !owner_vld);
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // FSM next state: arbitrate in IDLE, leave BURST on burst limit or dropped valid
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (found) state_nxt = BURST;
         BURST:   if (exit_burst) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // FSM outputs: grant/ready only while bursting, write data zeroed outside a beat
   always_comb begin
      grant     = '0;
      req_ready = '0;
      fifo_wr   = beat;
      fifo_din  = beat ? data_arr[owner] : '0;
      if (state == BURST) begin
         grant     = {{(N-1){1'b0}}, 1'b1} << owner;
         req_ready = can_wr ? grant : '0;
      end
   end

   // Owner capture, beat counting and round-robin pointer advance
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner    <= '0;
         beat_cnt <= '0;
         rr_ptr   <= '0;
      end else begin
         if (state == IDLE && found) begin
            owner    <= winner;
            beat_cnt <= '0;
         end else if (beat) begin
            beat_cnt <= beat_cnt + 4'd1;
         end
         if (exit_burst) rr_ptr <= (owner == PW'(N - 1)) ? '0 : owner + 1'b1;
      end
   end

   // Credit tracking: writes consume, pops return; a pop at full credit flags overflow
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         credit  <= CRD_MAX;
         ovf_err <= 1'b0;
      end else if (beat && !fifo_pop) begin
         credit <= credit - 4'd1;
      end else if (fifo_pop && !beat) begin
         if (credit == CRD_MAX) ovf_err <= 1'b1;
         else                   credit  <= credit + 4'd1;
      end
   end

`ifdef FIFO_ARB_STATS_EN
   logic [15:0] stat_q [N];

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // Per-requester beat counters, saturating
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N; i++) stat_q[i] <= '0;
      end else if (beat) begin
         stat_q[owner] <= sat_inc(stat_q[owner]);
      end
   end

   // Counter readback; out-of-range selects read as zero
   always_comb begin
      stat_cnt = '0;
      for (int i = 0; i < N; i++) begin
         if (stat_sel == 3'(i)) stat_cnt = stat_q[i];
      end
   end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a behavioural model.
module tb_fifo_wr_arbiter;

   localparam int N         = 4;
   localparam int DW        = 8;
   localparam int DEPTH     = 8;
   localparam int MAX_BURST = 4;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [N-1:0]    req_valid = '0;
   logic [N*DW-1:0] req_data = '0;
   logic [N-1:0]    req_ready;
   logic            fifo_wr;
   logic [DW-1:0]   fifo_din;
   logic            fifo_full = 1'b0;
   logic            fifo_pop = 1'b0;
   logic [N-1:0]    grant;
   logic [3:0]      credit;
   logic            ovf_err;
`ifdef FIFO_ARB_STATS_EN
   logic [2:0]      stat_sel = 3'd0;
   logic [15:0]     stat_cnt;
`endif

   fifo_wr_arbiter #(.N(N), .DW(DW), .DEPTH(DEPTH), .MAX_BURST(MAX_BURST)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .fifo_wr   (fifo_wr),
      .fifo_din  (fifo_din),
      .fifo_full (fifo_full),
      .fifo_pop  (fifo_pop),
      .grant     (grant),
      .credit    (credit),
      .ovf_err   (ovf_err)
`ifdef FIFO_ARB_STATS_EN
      ,
      .stat_sel  (stat_sel),
      .stat_cnt  (stat_cnt)
`endif
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h required %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model (checked every negedge) ----------------
   int         m_owner;   // -1 = nobody owns the port
   int         m_rr, m_beats, m_credit, m_idx;
   bit         m_ovf, m_found, m_can, m_beat;
   logic [7:0] cur_d [N];
   logic [3:0] e_grant, e_ready;
   logic [7:0] e_din;

   always @(negedge clk) begin
      if (!rst_n) begin
         m_owner = -1; m_rr = 0; m_beats = 0; m_credit = DEPTH; m_ovf = 0;
         chk("rst_grant", 32'(grant), 0);
         chk("rst_ready", 32'(req_ready), 0);
         chk("rst_wr", 32'(fifo_wr), 0);
         chk("rst_din", 32'(fifo_din), 0);
         chk("rst_credit", 32'(credit), DEPTH);
         chk("rst_ovf", 32'(ovf_err), 0);
      end else begin
         m_can  = (m_credit != 0) && !fifo_full;
         m_beat = 0;
         e_grant = '0; e_ready = '0; e_din = '0;
         if (m_owner >= 0) begin
            e_grant = 4'd1 << m_owner;
            if (m_can) e_ready = e_grant;
            m_beat = req_valid[2'(m_owner)] && m_can;
            if (m_beat) e_din = cur_d[2'(m_owner)];
         end
         chk("grant", 32'(grant), 32'(e_grant));
         chk("req_ready", 32'(req_ready), 32'(e_ready));
         chk("fifo_wr", 32'(fifo_wr), 32'(m_beat));
         chk("fifo_din", 32'(fifo_din), 32'(e_din));
         chk("credit", 32'(credit), 32'(m_credit));
         chk("ovf_err", 32'(ovf_err), 32'(m_ovf));
         // advance to the state after the coming rising edge
         if (m_beat && !fifo_pop) m_credit--;
         else if (fifo_pop && !m_beat) begin
            if (m_credit == DEPTH) m_ovf = 1;
            else m_credit++;
         end
         if (m_owner < 0) begin
            m_found = 0;
            for (int k = 0; k < N; k++) begin
               m_idx = (m_rr + k) % N;
               if (!m_found && req_valid[2'(m_idx)]) begin
                  m_found = 1; m_owner = m_idx; m_beats = 0;
               end
            end
         end else if ((m_beat && (m_beats + 1 == MAX_BURST)) ||
                      (!m_beat && !req_valid[2'(m_owner)])) begin
            m_rr = (m_owner + 1) % N;
            m_owner = -1;
         end else if (m_beat) begin
            m_beats++;
         end
      end
   end

   // ---------------- stimulus ----------------
   logic [7:0] base [N];
   logic [7:0] seq  [N];
   logic [N-1:0] acc = '0;

   task automatic adv_seq();
      for (int i = 0; i < N; i++) if (acc[i]) seq[i] = seq[i] + 8'd1;
      for (int i = 0; i < N; i++) cur_d[i] = base[i] + seq[i];
      req_data = {cur_d[3], cur_d[2], cur_d[1], cur_d[0]};
   endtask

   // One clock: apply inputs after the edge, return at the following negedge
   task automatic cyc(input logic [3:0] v, input logic p, input logic f);
      @(posedge clk); #1;
      adv_seq();
      req_valid = v; fifo_pop = p; fifo_full = f;
      @(negedge clk);
      acc = req_valid & req_ready;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      adv_seq();
      rst_n = 1'b0; req_valid = '0; fifo_pop = 1'b0; fifo_full = 1'b0;
      @(negedge clk);
      acc = '0;
      chk("reset_grant", 32'(grant), 0);
      chk("reset_wr", 32'(fifo_wr), 0);
      chk("reset_credit", 32'(credit), 8);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   logic [3:0] t1_g [10] = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h1, 4'h1, 4'h1, 4'h1};
   logic [7:0] t1_d [10] = '{8'h00, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'h00, 8'hA4, 8'hA5, 8'hA6, 8'hA7};
   logic [3:0] t2_g [12] = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h4, 4'h4, 4'h4, 4'h4, 4'h0, 4'h1};
   logic [3:0] t5_g [6]  = '{4'h0, 4'h8, 4'h8, 4'h8, 4'h0, 4'h1};
   logic [3:0] t5_v [6]  = '{4'h8, 4'h8, 4'h8, 4'h1, 4'h1, 4'h1};
   logic [3:0] rv;

   initial begin
      for (int i = 0; i < N; i++) begin
         base[i] = 8'(i * 16); seq[i] = 8'd0; cur_d[i] = base[i];
      end
      base[0] = 8'hA0;
      repeat (2) @(posedge clk);
      do_reset();

      // single requester, two bursts of four, credit drains to zero
      for (int c = 0; c < 10; c++) begin
         cyc(4'b0001, 1'b0, 1'b0);
         chk("t1_grant", 32'(grant), 32'(t1_g[c]));
         chk("t1_din", 32'(fifo_din), 32'(t1_d[c]));
      end
      cyc(4'b0000, 1'b0, 1'b0);
      chk("t1_credit0", 32'(credit), 0);

      // credit exhaustion: owner waits, one pop lets exactly one beat through
      cyc(4'b0010, 1'b0, 1'b0);
      cyc(4'b0010, 1'b0, 1'b0);
      chk("t3_grant", 32'(grant), 32'h2);
      chk("t3_ready0", 32'(req_ready), 0);
      chk("t3_wr0", 32'(fifo_wr), 0);
      cyc(4'b0010, 1'b1, 1'b0);
      chk("t3_wr_pop", 32'(fifo_wr), 0);
      cyc(4'b0010, 1'b0, 1'b0);
      chk("t3_wr1", 32'(fifo_wr), 1);
      chk("t3_credit1", 32'(credit), 1);
      cyc(4'b0010, 1'b0, 1'b0);
      chk("t3_wr_after", 32'(fifo_wr), 0);
      chk("t3_credit_after", 32'(credit), 0);
      cyc(4'b0000, 1'b0, 1'b0);

      // contention between req 0 and req 2 with a pop every cycle
      do_reset();
      for (int c = 0; c < 12; c++) begin
         cyc(4'b0101, 1'b1, 1'b0);
         chk("t2_grant", 32'(grant), 32'(t2_g[c]));
      end

      // simultaneous write and pop at credit 3
      do_reset();
      for (int c = 0; c < 7; c++) cyc(4'b0001, 1'b0, 1'b0);
      cyc(4'b0001, 1'b1, 1'b0);
      chk("t4_wr", 32'(fifo_wr), 1);
      chk("t4_credit3", 32'(credit), 3);
      cyc(4'b0000, 1'b0, 1'b0);
      chk("t4_credit_hold", 32'(credit), 3);

      // pop at full credit raises the sticky overflow flag
      do_reset();
      cyc(4'b0000, 1'b1, 1'b0);
      cyc(4'b0000, 1'b0, 1'b0);
      chk("t4_ovf", 32'(ovf_err), 1);
      chk("t4_ovf_credit", 32'(credit), 8);

      // early release by req 3, req 0 picked up next
      do_reset();
      for (int c = 0; c < 6; c++) begin
         cyc(t5_v[c], 1'b0, 1'b0);
         chk("t5_grant", 32'(grant), 32'(t5_g[c]));
      end

      // reset in the middle of a burst, arbitration restarts from index 0
      do_reset();
      cyc(4'b0001, 1'b0, 1'b0);
      cyc(4'b0001, 1'b0, 1'b0);
      cyc(4'b0001, 1'b0, 1'b0);
      do_reset();
      cyc(4'b1010, 1'b0, 1'b0);
      chk("t6_idle", 32'(grant), 0);
      cyc(4'b1010, 1'b0, 1'b0);
      chk("t6_grant", 32'(grant), 32'h2);

      // randomized traffic; valids held until accepted most of the time
      for (int i = 0; i < N; i++) base[i] = 8'($urandom_range(0, 255));
      rv = '0;
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < N; i++) begin
            if (rv[i] && acc[i]) rv[i] = ($urandom_range(0, 3) != 0);
            else if (rv[i])      rv[i] = ($urandom_range(0, 15) != 0);
            else                 rv[i] = ($urandom_range(0, 2) == 0);
         end
         cyc(rv, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
         if (c == 1500) do_reset();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
